// File: rtl/display_pkg.sv
// Shared encodings for the display time-sharing scheduler.
package display_pkg;
    localparam int DISP_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHOW  = 2'd1;
    localparam state_t ST_ALERT = 2'd2;
endpackage

// File: rtl/rr_picker.sv
// Round-robin pick: first asserted request searching from last+1 with wrap (last itself is checked last).
// Combinational, zero latency; no backpressure.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);
    // Walk farthest-to-nearest so the nearest hit is the one that sticks.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            if (((req >> ((int'(last) + k) % N)) & N'(1)) != '0) begin
                found = 1'b1;
                idx   = IW'((int'(last) + k) % N);
            end
        end
    end
endmodule

// File: rtl/display_scheduler.sv
// Time-shares the display between round-robin sources with a preempting alert; registered outputs,
// decisions visible one edge after inputs are sampled; no backpressure (requests are levels, alert is a strobe).
module display_scheduler
    import display_pkg::*;
#(
    parameter int                NUM_SRC      = 4,
    parameter int                DWELL_CYCLES = 1000,
    parameter int                ALERT_HOLD   = 500,
    parameter logic [DISP_W-1:0] BLANK_VALUE  = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_req,
    input  logic [NUM_SRC*DISP_W-1:0] src_value,
    input  logic                      alert_req,
    input  logic [DISP_W-1:0]         alert_value,
    output logic [DISP_W-1:0]         display_value,
    output logic [NUM_SRC-1:0]        grant,
    output logic                      alert_active,
    output logic                      slot_done
);
    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int HW = (ALERT_HOLD > 1) ? $clog2(ALERT_HOLD) : 1;

    state_t            state, state_nx;
    logic [IW-1:0]     last, last_nx, resume_idx, resume_idx_nx;
    logic              resume_vld, resume_vld_nx;
    logic [DW-1:0]     dwell_cnt, dwell_nx;
    logic [HW-1:0]     hold_cnt, hold_nx;
    logic [DISP_W-1:0] disp_nx;
    logic [NUM_SRC-1:0] grant_nx;
    logic              alert_nx, done_nx;

    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic              go_alert, go_show, dwell_end;
    logic [IW-1:0]     go_idx;
    logic [DISP_W-1:0] vals [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign vals[i] = src_value[DISP_W*i +: DISP_W];
    end

    rr_picker #(.N(NUM_SRC), .IW(IW)) u_pick (
        .req   (src_req),
        .last  (last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign dwell_end = (dwell_cnt == DW'(DWELL_CYCLES - 1));

    always_comb begin
        state_nx      = state;
        last_nx       = last;
        resume_idx_nx = resume_idx;
        resume_vld_nx = resume_vld;
        dwell_nx      = dwell_cnt;
        hold_nx       = hold_cnt;
        disp_nx       = BLANK_VALUE;
        grant_nx      = '0;
        alert_nx      = 1'b0;
        done_nx       = 1'b0;
        go_alert      = 1'b0;
        go_show       = 1'b0;
        go_idx        = pick_idx;

        case (state)
            ST_IDLE: begin
                if (alert_req) begin
                    go_alert      = 1'b1;
                    resume_vld_nx = 1'b0;
                end else if (pick_found) begin
                    go_show = 1'b1;
                end
            end
            ST_SHOW: begin
                if (alert_req) begin
                    // At expiry the slot is already complete, so resume with the next source instead.
                    go_alert      = 1'b1;
                    resume_vld_nx = dwell_end ? pick_found : 1'b1;
                    resume_idx_nx = dwell_end ? pick_idx : last;
                end else if (dwell_end || !src_req[last]) begin
                    go_show  = pick_found;
                    state_nx = ST_IDLE;
                    dwell_nx = '0;
                end else begin
                    dwell_nx = dwell_cnt + DW'(1);
                    disp_nx  = vals[last];
                    grant_nx = NUM_SRC'(1) << last;
                    // Registered pulse lands on the final cycle of the slot.
                    done_nx  = (dwell_cnt == DW'(DWELL_CYCLES - 2));
                end
            end
            ST_ALERT: begin
                if (alert_req) begin
                    go_alert = 1'b1;
                end else if (hold_cnt == HW'(ALERT_HOLD - 1)) begin
                    resume_vld_nx = 1'b0;
                    hold_nx       = '0;
                    state_nx      = ST_IDLE;
                    if (resume_vld && src_req[resume_idx]) begin
                        go_show = 1'b1;
                        go_idx  = resume_idx;
                    end else begin
                        go_show = pick_found;
                    end
                end else begin
                    hold_nx  = hold_cnt + HW'(1);
                    disp_nx  = display_value;
                    alert_nx = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        if (go_alert) begin
            state_nx = ST_ALERT;
            hold_nx  = '0;
            dwell_nx = '0;
            disp_nx  = alert_value;
            alert_nx = 1'b1;
        end else if (go_show) begin
            state_nx = ST_SHOW;
            last_nx  = go_idx;
            dwell_nx = '0;
            hold_nx  = '0;
            disp_nx  = vals[go_idx];
            grant_nx = NUM_SRC'(1) << go_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            last          <= IW'(NUM_SRC - 1);
            resume_idx    <= '0;
            resume_vld    <= 1'b0;
            dwell_cnt     <= '0;
            hold_cnt      <= '0;
            display_value <= BLANK_VALUE;
            grant         <= '0;
            alert_active  <= 1'b0;
            slot_done     <= 1'b0;
        end else begin
            state         <= state_nx;
            last          <= last_nx;
            resume_idx    <= resume_idx_nx;
            resume_vld    <= resume_vld_nx;
            dwell_cnt     <= dwell_nx;
            hold_cnt      <= hold_nx;
            display_value <= disp_nx;
            grant         <= grant_nx;
            alert_active  <= alert_nx;
            slot_done     <= done_nx;
        end
    end
endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench: expected per-cycle outputs are queued as stimulus is applied and checked each cycle.
module tb_display_scheduler;
    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    src_req;
    logic [127:0]  src_value;
    logic          alert_req;
    logic [31:0]   alert_value;
    logic [31:0]   display_value;
    logic [3:0]    grant;
    logic          alert_active;
    logic          slot_done;

    typedef struct packed {
        logic [31:0] dv;
        logic [3:0]  g;
        logic        aa;
        logic        sd;
    } exp_t;

    exp_t  q [$];
    string tq [$];
    int    tests  = 0;
    int    failed = 0;

    display_scheduler #(
        .NUM_SRC(4), .DWELL_CYCLES(8), .ALERT_HOLD(5), .BLANK_VALUE(32'h0000_0000)
    ) dut (
        .clk(clk), .reset(reset), .src_req(src_req), .src_value(src_value),
        .alert_req(alert_req), .alert_value(alert_value),
        .display_value(display_value), .grant(grant),
        .alert_active(alert_active), .slot_done(slot_done)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [31:0] dv, input logic [3:0] g, input logic aa,
                        input logic sd, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            q.push_back('{dv: dv, g: g, aa: aa, sd: sd});
            tq.push_back($sformatf("%s[%0d]", tag, i));
        end
    endtask

    task automatic check();
        exp_t  e;
        string t;
        if (q.size() == 0) begin
            tests++;
            failed++;
            $error("FAIL scoreboard_empty: got output with no expectation queued");
            return;
        end
        e = q.pop_front();
        t = tq.pop_front();
        tests++;
        assert (display_value === e.dv) else begin
            failed++;
            $error("FAIL %s display_value got %h expected %h", t, display_value, e.dv);
        end
        tests++;
        assert (grant === e.g) else begin
            failed++;
            $error("FAIL %s grant got %b expected %b", t, grant, e.g);
        end
        tests++;
        assert (alert_active === e.aa) else begin
            failed++;
            $error("FAIL %s alert_active got %b expected %b", t, alert_active, e.aa);
        end
        tests++;
        assert (slot_done === e.sd) else begin
            failed++;
            $error("FAIL %s slot_done got %b expected %b", t, slot_done, e.sd);
        end
    endtask

    // Each iteration consumes one expectation, so the loop is bounded by what was queued.
    task automatic run_all();
        while (q.size() > 0) begin
            @(posedge clk);
            #1;
            check();
        end
    endtask

    task automatic set_val(input int i, input logic [31:0] v);
        src_value[32*i +: 32] = v;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        src_req     = 4'b1111;
        alert_req   = 1'b0;
        alert_value = 32'h0;
        src_value   = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

        #2;
        push(32'h0, 4'b0000, 1'b0, 1'b0, 1, "reset_async");
        check();
        push(32'h0, 4'b0000, 1'b0, 1'b0, 2, "reset_held_with_req");
        run_all();

        reset   = 1'b1;
        src_req = 4'b0000;
        push(32'h0, 4'b0000, 1'b0, 1'b0, 3, "idle_no_req");
        run_all();

        src_req = 4'b0101;
        push(32'h1111_1111, 4'b0001, 1'b0, 1'b0, 7, "rot_src0");
        push(32'h1111_1111, 4'b0001, 1'b0, 1'b1, 1, "rot_src0_done");
        push(32'h3333_3333, 4'b0100, 1'b0, 1'b0, 7, "rot_src2");
        push(32'h3333_3333, 4'b0100, 1'b0, 1'b1, 1, "rot_src2_done");
        push(32'h1111_1111, 4'b0001, 1'b0, 1'b0, 4, "rot_back_src0");
        run_all();

        // Source 0 is at dwell count 3.
        src_req = 4'b0100;
        push(32'h3333_3333, 4'b0100, 1'b0, 1'b0, 1, "drop_to_src2");
        run_all();

        set_val(2, 32'h3333_AAAA);
        push(32'h3333_AAAA, 4'b0100, 1'b0, 1'b0, 6, "single_val_a");
        push(32'h3333_AAAA, 4'b0100, 1'b0, 1'b1, 1, "single_done1");
        push(32'h3333_AAAA, 4'b0100, 1'b0, 1'b0, 1, "single_repick");
        run_all();
        set_val(2, 32'h3333_BBBB);
        push(32'h3333_BBBB, 4'b0100, 1'b0, 1'b0, 6, "single_val_b");
        push(32'h3333_BBBB, 4'b0100, 1'b0, 1'b1, 1, "single_done2");
        run_all();

        src_req = 4'b0101;
        push(32'h1111_1111, 4'b0001, 1'b0, 1'b0, 5, "pre_alert_src0");
        run_all();

        alert_req   = 1'b1;
        alert_value = 32'hDEAD_BEEF;
        push(32'hDEAD_BEEF, 4'b0000, 1'b1, 1'b0, 1, "alert_accept");
        run_all();
        alert_req = 1'b0;
        push(32'hDEAD_BEEF, 4'b0000, 1'b1, 1'b0, 4, "alert_hold");
        push(32'h1111_1111, 4'b0001, 1'b0, 1'b0, 7, "resume_src0");
        push(32'h1111_1111, 4'b0001, 1'b0, 1'b1, 1, "resume_src0_done");
        run_all();

        // Alert coincides with slot expiry: resume goes to the round-robin next (source 2).
        alert_req   = 1'b1;
        alert_value = 32'h1234_5678;
        push(32'h1234_5678, 4'b0000, 1'b1, 1'b0, 1, "alert_at_expiry");
        run_all();
        alert_req = 1'b0;
        push(32'h1234_5678, 4'b0000, 1'b1, 1'b0, 3, "alert2_hold");
        run_all();

        alert_req   = 1'b1;
        alert_value = 32'hCAFE_F00D;
        push(32'hCAFE_F00D, 4'b0000, 1'b1, 1'b0, 1, "retrigger");
        run_all();
        alert_req = 1'b0;
        push(32'hCAFE_F00D, 4'b0000, 1'b1, 1'b0, 4, "retrigger_hold");
        push(32'h3333_BBBB, 4'b0100, 1'b0, 1'b0, 3, "resume_rr_src2");
        run_all();

        #3;
        reset = 1'b0;
        #1;
        push(32'h0, 4'b0000, 1'b0, 1'b0, 1, "async_reset_mid_show");
        check();
        src_req = 4'b1010;
        push(32'h0, 4'b0000, 1'b0, 1'b0, 2, "reset_held_again");
        run_all();
        #2;
        reset = 1'b1;
        push(32'h2222_2222, 4'b0010, 1'b0, 1'b0, 1, "post_reset_first_grant");
        run_all();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-shares the 4-digit multiplexed display between several value producers and a priority alert source. Sits directly upstream of the digit-multiplexing display controller: its `display_value` output drives that controller's `display_value` input. Requesters are served round-robin for a fixed dwell time each. An alert preempts the rotation for a fixed hold time.

## Interface
Parameters:
- `NUM_SRC`, 4, number of round-robin requesters (≥1)
- `DWELL_CYCLES`, 1000, clock cycles each granted source is shown (≥2)
- `ALERT_HOLD`, 500, clock cycles an alert is shown (≥1)
- `BLANK_VALUE`, 32'h0000_0000, value driven when nothing is granted

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `src_req`  in  NUM_SRC  level request per source
- `src_value`  in  NUM_SRC*32  packed values; source i at bits [32i+31:32i]
- `alert_req`  in  1  single-cycle alert strobe
- `alert_value`  in  32  alert value, sampled when `alert_req` is accepted
- `display_value`  out  32  value to the display controller (registered)
- `grant`  out  NUM_SRC  one-hot current source; all zero in IDLE/ALERT
- `alert_active`  out  1  high while in ALERT
- `slot_done`  out  1  one-cycle pulse when a dwell completes in full

## Operation
- States: IDLE, SHOW, ALERT.
- Round-robin pointer `last` holds the index of the most recently granted source. The next pick is the first asserted `src_req` searching from `last+1` with wrap. If the current source is the only requester, it is re-picked.
- IDLE:
  - `alert_req` -> ALERT.
  - Else any `src_req` -> SHOW with the picked source, dwell count = 0.
- SHOW:
  - `display_value` follows `src_value[granted]` live: re-registered every cycle.
  - Dwell count increments each cycle.
  - At count = DWELL_CYCLES-1: pulse `slot_done`, then pick next. If none, go to IDLE.
  - If the granted source's `src_req` drops mid-slot: no `slot_done`. Pick next immediately, or go to IDLE.
  - `alert_req` -> ALERT. Save the resume index, which is the current source.
- ALERT:
  - Latch `alert_value` on acceptance.
  - Hold count runs 0..ALERT_HOLD-1.
  - `alert_req` during ALERT relatches the value and restarts the hold count.
  - On expiry:
    - If the resume source is still requesting, grant it with a fresh dwell (count 0).
    - Else round-robin pick.
    - Else IDLE.
  - An alert accepted from IDLE has no resume source.
- Simultaneous events:
  - `alert_req` wins over slot expiry and over a request drop.
  - At expiry plus alert, `slot_done` still pulses and the resume index is the round-robin next source.
- Counter widths: `$clog2(DWELL_CYCLES)` and `$clog2(ALERT_HOLD)`, with a minimum of 1 bit. Counters never exceed their terminal value.

## Timing
- Reset values (async, immediate):
  - `display_value` = BLANK_VALUE, `grant` = 0, `alert_active` = 0, `slot_done` = 0.
  - State IDLE, counters 0, `last` = NUM_SRC-1, so source 0 wins first.
- All outputs are registered. A decision made at edge N is visible after edge N.
- `src_req` asserted before edge N in IDLE -> `grant` and `display_value` are valid after edge N.
- A full slot shows a source for exactly DWELL_CYCLES cycles. The next grant appears on the cycle following the `slot_done` cycle, with no blank gap.
- `alert_req` sampled at edge N -> `alert_active` = 1 and `display_value` = alert value after edge N, for exactly ALERT_HOLD cycles.
- `src_value` changes during SHOW appear on `display_value` one cycle later.
- Reset deasserted mid-operation restarts cleanly from IDLE. Reset is not required to be synchronized inside this block.

## Structure
- Shared package `display_pkg`:
  - State encoding localparams `ST_IDLE`, `ST_SHOW`, `ST_ALERT`.
  - `DISP_W` = 32.
- Sub-module `rr_picker` (combinational):
  - Inputs: request mask and `last` pointer.
  - Outputs: `found` flag and picked index.
  - Used at every pick point.

## Test plan
Bench parameters: NUM_SRC=4, DWELL_CYCLES=8, ALERT_HOLD=5.
- Reset: hold `reset`=0 with `src_req`=4'b1111 -> `display_value`=0, `grant`=0, `slot_done`=0. Release with no requests -> stays IDLE.
- Rotation: `src_req`=4'b0101, values 0x11111111 and 0x33333333 -> `grant`=0001 for 8 cycles, `slot_done` pulse, `grant`=0100 for 8, back to 0001, with no blank cycle.
- Single requester: only source 2 -> `grant`=0100 continuously, `slot_done` every 8 cycles, `display_value` tracks a changing `src_value` with 1-cycle lag.
- Drop mid-slot: source 0 drops at dwell count 3 while source 2 is requesting -> `grant`=0100 next cycle, no `slot_done`.
- Alert preempt: alert_value 0xDEADBEEF at source 0 dwell count 4 -> `alert_active` and `display_value`=DEADBEEF for 5 cycles, `grant`=0, then source 0 regranted for a full 8. A retrigger at hold count 3 with 0xCAFEF00D -> CAFEF00D shown for 5 further cycles.
- Async reset mid-SHOW: drop `reset` between clock edges -> outputs at reset values immediately, and the first grant after release goes to the lowest requesting index.
